pseudo_spi_xfer: RTL and testbench

Parametrised full-duplex successor to the team's pseudo-SPI SRAM streamer. It walks an SRAM region from a start address, reading one word per step. Each word is shifted out bit by bit under two-phase non-overlapping clocks (SCLK1/SCLK2), with a programmable divider and selectable bit order and address direction. It can optionally capture the returning serial bit stream and write each received word back in place. LAT is pulsed at the end of the transfer. The block sits between the CPU-side SRAM port and the analog scan chain.

---
 rtl/pseudo_spi_pkg.sv | 34 +++
 rtl/pseudo_spi_phase_gen.sv | 48 ++++
 rtl/pseudo_spi_xfer.sv | 175 +++++++++++++++++
 tb/tb_pseudo_spi_xfer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pseudo_spi_pkg.sv
// pseudo_spi_pkg: shared state/phase encodings and latency helper
// for the pseudo-SPI SRAM streamer.
package pseudo_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD,
    ST_SHIFT,
    ST_WRITE,
    ST_NEXT,
    ST_LATCH,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_e;

  // Edge index after which DONE is high, START sampled at edge 0.
  function automatic int unsigned xfer_cycles(
    input int unsigned n,
    input int unsigned w,
    input int unsigned d,
    input int unsigned c
  );
    if (n == 0) return 1;
    return n * (3 + c + 4 * w * (d + 1)) + (d + 1) + 1;
  endfunction

endpackage

// File: rtl/pseudo_spi_phase_gen.sv
// pseudo_spi_phase_gen: divider and quarter counter producing the
// two-phase non-overlapping clocks and per-bit strobes.
module pseudo_spi_phase_gen
  import pseudo_spi_pkg::*;
#(
  parameter int FREQ_DIV_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      en,
  input  logic [FREQ_DIV_WIDTH-1:0] div,
  output logic                      sclk1,
  output logic                      sclk2,
  output logic                      shift_stb,
  output logic                      sample_stb,
  output logic                      bit_end
);

  logic [FREQ_DIV_WIDTH-1:0] div_cnt;
  quarter_e                  quarter;
  logic                      q_end;
  logic                      q3_last;

  assign q_end = (div_cnt == div);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
      quarter <= Q0;
    end else if (!en) begin
      div_cnt <= '0;
      quarter <= Q0;
    end else if (q_end) begin
      div_cnt <= '0;
      quarter <= quarter_e'(quarter + 2'd1);
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign q3_last    = en && (quarter == Q3) && q_end;
  assign sclk1      = en && (quarter == Q1);
  assign sclk2      = en && (quarter == Q3);
  assign sample_stb = q3_last;
  assign shift_stb  = q3_last;
  assign bit_end    = q3_last;

endmodule

// File: rtl/pseudo_spi_xfer.sv
// pseudo_spi_xfer: walks an SRAM region, shifts each word out on
// SCLK1/SCLK2 and optionally writes the captured return word back.
module pseudo_spi_xfer
  import pseudo_spi_pkg::*;
#(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int RESERVED_DATA_LEN = 8,
  parameter int FREQ_DIV_WIDTH    = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic [FREQ_DIV_WIDTH-1:0]    FREQ_DIV,
  input  logic                         MSB_FIRST,
  input  logic                         ADDR_DEC,
  input  logic                         CAPTURE_EN,
  input  logic [MEMORY_DATA_WIDTH-1:0] PI,
  input  logic                         SPI_SI,
  output logic                         SCLK1,
  output logic                         SCLK2,
  output logic                         LAT,
  output logic                         SPI_SO,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic                         CEN,
  output logic                         WEN,
  output logic [MEMORY_DATA_WIDTH-1:0] PO,
  output logic                         BUSY,
  output logic                         DONE
);

  localparam int W  = MEMORY_DATA_WIDTH;
  localparam int BW = $clog2(W + 1);

  state_e state, state_d;

  logic [MEMORY_ADDR_WIDTH-1:0] addr_q;
  logic [RESERVED_DATA_LEN-1:0] len_q;
  logic [RESERVED_DATA_LEN-1:0] words_left;
  logic [FREQ_DIV_WIDTH-1:0]    div_q;
  logic                         msb_q;
  logic                         dec_q;
  logic                         cap_q;
  logic [W-1:0]                 sreg;
  logic [W-1:0]                 crx;
  logic [BW-1:0]                bit_cnt;
  logic [FREQ_DIV_WIDTH-1:0]    lat_cnt;
  logic                         done_q;
  logic [31:0]                  elapsed;

  logic start_ok;
  logic sclk1, sclk2, shift_stb, sample_stb, bit_end;

  // A START landing on the DONE pulse is dropped via done_q.
  assign start_ok = START && (state == ST_IDLE) && !done_q;

  pseudo_spi_phase_gen #(
    .FREQ_DIV_WIDTH(FREQ_DIV_WIDTH)
  ) u_phase (
    .CLK       (CLK),
    .RST       (RST),
    .en        (state == ST_SHIFT),
    .div       (div_q),
    .sclk1     (sclk1),
    .sclk2     (sclk2),
    .shift_stb (shift_stb),
    .sample_stb(sample_stb),
    .bit_end   (bit_end)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (start_ok)
          state_d = (DATA_LEN == '0) ? ST_DONE : ST_READ;
      end
      ST_READ:  state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (bit_end && bit_cnt == BW'(1))
          state_d = cap_q ? ST_WRITE : ST_NEXT;
      end
      ST_WRITE: state_d = ST_NEXT;
      ST_NEXT: begin
        state_d = (words_left == RESERVED_DATA_LEN'(1))
                ? ST_LATCH : ST_READ;
      end
      ST_LATCH: begin
        if (lat_cnt == div_q) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q     <= '0;
      len_q      <= '0;
      words_left <= '0;
      div_q      <= '0;
      msb_q      <= 1'b0;
      dec_q      <= 1'b0;
      cap_q      <= 1'b0;
      sreg       <= '0;
      crx        <= '0;
      bit_cnt    <= '0;
      lat_cnt    <= '0;
      done_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q     <= ADDR_BGN;
        len_q      <= DATA_LEN;
        words_left <= DATA_LEN;
        div_q      <= FREQ_DIV;
        msb_q      <= MSB_FIRST;
        dec_q      <= ADDR_DEC;
        cap_q      <= CAPTURE_EN;
      end
      if (state == ST_LOAD) begin
        sreg    <= PI;
        crx     <= '0;
        bit_cnt <= BW'(W);
      end
      if (shift_stb)
        sreg <= msb_q ? (sreg << 1) : (sreg >> 1);
      if (sample_stb)
        crx <= msb_q ? {crx[W-2:0], SPI_SI}
                     : {SPI_SI, crx[W-1:1]};
      if (bit_end)
        bit_cnt <= bit_cnt - 1'b1;
      if (state == ST_NEXT) begin
        addr_q     <= dec_q ? addr_q - 1'b1 : addr_q + 1'b1;
        words_left <= words_left - 1'b1;
      end
      lat_cnt <= (state == ST_LATCH) ? lat_cnt + 1'b1 : '0;
      done_q  <= (state == ST_DONE);
    end
  end

  assign SCLK1  = sclk1;
  assign SCLK2  = sclk2;
  assign LAT    = (state == ST_LATCH);
  assign SPI_SO = (state == ST_SHIFT) && (msb_q ? sreg[W-1] : sreg[0]);
  assign CEN    = !((state == ST_READ) || (state == ST_WRITE));
  assign WEN    = (state != ST_WRITE);
  assign A      = CEN ? '0 : addr_q;
  assign PO     = (state == ST_WRITE) ? crx : '0;
  assign BUSY   = (state != ST_IDLE) || done_q;
  assign DONE   = done_q;

  // Cycles since the accepted START, for the latency check only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    elapsed <= '0;
    else if (start_ok)          elapsed <= '0;
    else if (state != ST_IDLE)  elapsed <= elapsed + 1'b1;
  end

  a_no_overlap: assert property (
    @(posedge CLK) disable iff (RST) !(SCLK1 && SCLK2));

  a_latency: assert property (
    @(posedge CLK) disable iff (RST)
    done_q |-> (elapsed == xfer_cycles(32'(len_q), 32'(W),
                                       32'(div_q), 32'(cap_q))));

endmodule

// File: tb/tb_pseudo_spi_xfer.sv
// tb_pseudo_spi_xfer: timeline reference model plus randomized
// transfers for pseudo_spi_xfer.
module tb_pseudo_spi_xfer;
  import pseudo_spi_pkg::*;

  localparam int W  = 8;
  localparam int AW = 9;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [AW-1:0] ADDR_BGN;
  logic [7:0]    DATA_LEN;
  logic [7:0]    FREQ_DIV;
  logic          MSB_FIRST, ADDR_DEC, CAPTURE_EN;
  logic [W-1:0]  PI;
  logic          SPI_SI;
  logic          SCLK1, SCLK2, LAT, SPI_SO, CEN, WEN, BUSY, DONE;
  logic [AW-1:0] A;
  logic [W-1:0]  PO;

  always #5 CLK = ~CLK;

  pseudo_spi_xfer dut (
    .CLK(CLK), .RST(RST), .START(START), .ADDR_BGN(ADDR_BGN),
    .DATA_LEN(DATA_LEN), .FREQ_DIV(FREQ_DIV), .MSB_FIRST(MSB_FIRST),
    .ADDR_DEC(ADDR_DEC), .CAPTURE_EN(CAPTURE_EN), .PI(PI),
    .SPI_SI(SPI_SI), .SCLK1(SCLK1), .SCLK2(SCLK2), .LAT(LAT),
    .SPI_SO(SPI_SO), .A(A), .CEN(CEN), .WEN(WEN), .PO(PO),
    .BUSY(BUSY), .DONE(DONE)
  );

  logic [W-1:0] mem     [0:(1<<AW)-1];
  logic [W-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= PO;
      else      PI <= mem[A];
    end
  end

  typedef struct packed {
    logic        first;
    logic        start;
    logic        si;
    logic [24:0] out;
  } ent_t;

  ent_t tmp_q[$];
  ent_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int ent_idx, done_idx, dn_cnt;
  int s1_cnt, s2_cnt, lat_cnt, cen_cnt, wr_cnt;
  logic [15:0]   so_bits;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_a;
  logic [7:0]    wr_d;
  logic          prev_s1, prev_s2;

  function automatic logic [24:0] mk(
    input logic s1, s2, lat, so, input logic [8:0] a,
    input logic cen, wen, input logic [7:0] po,
    input logic busy, done);
    return {s1, s2, lat, so, a, cen, wen, po, busy, done};
  endfunction

  function automatic logic [24:0] dut_vec();
    return mk(SCLK1, SCLK2, LAT, SPI_SO, A, CEN, WEN, PO, BUSY, DONE);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [24:0] o, input logic si,
                      input logic st);
    ent_t e;
    e.first = (tmp_q.size() == 0);
    e.start = st;
    e.si    = si;
    e.out   = o;
    tmp_q.push_back(e);
  endtask

  task automatic setm(input logic [AW-1:0] a, input logic [7:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Expected output timeline, one entry per cycle after START edge.
  task automatic build(input logic [AW-1:0] bgn, input int n,
                       input int d, input bit msb, dec, cap, hold,
                       input bit use_si, input logic [7:0] si_fix);
    logic [AW-1:0] ad;
    logic [7:0]    data, rx;
    int            pos;
    tmp_q.delete();
    for (int i = 0; i < n; i++) begin
      ad   = dec ? bgn - AW'(i) : bgn + AW'(i);
      data = ref_mem[ad];
      rx   = use_si ? si_fix : 8'($urandom);
      push(mk(0, 0, 0, 0, ad, 0, 1, 0, 1, 0), 0, hold);
      push(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 0), 0, hold);
      for (int b = 0; b < W; b++) begin
        pos = msb ? W - 1 - b : b;
        for (int q = 0; q < 4; q++)
          for (int k = 0; k <= d; k++)
            push(mk(q == 1, q == 3, 0, data[pos], 0, 1, 1, 0, 1, 0),
                 rx[pos], hold);
      end
      if (cap) begin
        push(mk(0, 0, 0, 0, ad, 0, 0, rx, 1, 0), 0, hold);
        ref_mem[ad] = rx;
      end
      push(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 0), 0, hold);
    end
    if (n > 0)
      for (int k = 0; k <= d; k++)
        push(mk(0, 0, 1, 0, 0, 1, 1, 0, 1, 0), 0, hold);
    push(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 0), 0, hold);
    push(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 1), 0, hold);
    for (int k = 0; k < 3; k++)
      push(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 0, 0);
  endtask

  always @(negedge CLK) begin
    ent_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.first) begin
        ent_idx = 0; done_idx = -1; dn_cnt = 0;
        s1_cnt = 0; s2_cnt = 0; lat_cnt = 0; cen_cnt = 0;
        wr_cnt = 0; so_bits = '0; rd_log.delete();
        prev_s1 = 1'b0; prev_s2 = 1'b0;
        wr_a = '0; wr_d = '0;
      end
      chk($sformatf("cycle%0d", ent_idx), 32'(dut_vec()), 32'(e.out));
      if (DONE) begin done_idx = ent_idx; dn_cnt++; end
      if (SCLK1 && !prev_s1) begin
        s1_cnt++;
        so_bits = {so_bits[14:0], SPI_SO};
      end
      if (SCLK2 && !prev_s2) s2_cnt++;
      prev_s1 = SCLK1;
      prev_s2 = SCLK2;
      if (LAT) lat_cnt++;
      if (!CEN) cen_cnt++;
      if (!CEN && WEN) rd_log.push_back(A);
      if (!CEN && !WEN) begin wr_cnt++; wr_a = A; wr_d = PO; end
      ent_idx++;
    end
  end

  task automatic run(input logic [AW-1:0] bgn, input int n,
                     input int d, input bit msb, dec, cap, hold,
                     input bit use_si, input logic [7:0] si_fix,
                     input int abort_at);
    build(bgn, n, d, msb, dec, cap, hold, use_si, si_fix);
    @(negedge CLK);
    ADDR_BGN = bgn; DATA_LEN = 8'(n); FREQ_DIV = 8'(d);
    MSB_FIRST = msb; ADDR_DEC = dec; CAPTURE_EN = cap;
    START = 1'b1;
    @(posedge CLK);
    #1;
    exp_q = tmp_q;
    START = hold;
    for (int j = 0; j < tmp_q.size(); j++) begin
      @(negedge CLK);
      if (j == abort_at) begin
        #1;
        exp_q.delete();
        RST = 1'b1;
        #1;
        chk("abort_reset_vec", 32'(dut_vec()),
            32'(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0)));
        repeat (2) begin
          @(negedge CLK);
          chk("abort_quiet", 32'({BUSY, DONE, CEN}), 32'(3'b001));
        end
        RST = 1'b0;
        START = 1'b0;
        return;
      end
      SPI_SI = tmp_q[j].si;
      START  = tmp_q[j].start;
      if (tmp_q[j].out[1]) begin
        ADDR_BGN   = AW'($urandom);
        DATA_LEN   = 8'($urandom);
        FREQ_DIV   = 8'($urandom);
        MSB_FIRST  = 1'($urandom);
        ADDR_DEC   = 1'($urandom);
        CAPTURE_EN = 1'($urandom);
      end
    end
    #1;
    START = 1'b0;
  endtask

  initial begin
    int n, d, bad;
    bit msb, dec, cap;
    RST = 1'b1; START = 1'b0; SPI_SI = 1'b0;
    ADDR_BGN = '0; DATA_LEN = '0; FREQ_DIV = '0;
    MSB_FIRST = 0; ADDR_DEC = 0; CAPTURE_EN = 0;
    for (int i = 0; i < (1 << AW); i++) setm(AW'(i), 8'($urandom));
    repeat (3) @(negedge CLK);
    chk("reset_state", 32'(dut_vec()),
        32'(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0)));
    RST = 1'b0;

    setm(9'h010, 8'hA5); setm(9'h011, 8'h3C);
    run(9'h010, 2, 0, 0, 0, 0, 0, 0, 0, -1);
    chk("t1_so_bits", 32'(so_bits), 32'h0000_A53C);
    chk("t1_sclk1", s1_cnt, 16);
    chk("t1_sclk2", s2_cnt, 16);
    chk("t1_lat", lat_cnt, 1);
    chk("t1_done_edge", done_idx, 72);
    chk("t1_rd0", 32'(rd_log[0]), 32'h010);
    chk("t1_rd1", 32'(rd_log[1]), 32'h011);

    setm(9'h000, 8'hA5); setm(9'h1FF, 8'h3C);
    run(9'h000, 2, 0, 1, 1, 0, 0, 0, 0, -1);
    chk("t2_rd0", 32'(rd_log[0]), 32'h000);
    chk("t2_rd1_wrap", 32'(rd_log[1]), 32'h1FF);
    chk("t2_so_bits", 32'(so_bits), 32'h0000_A53C);

    setm(9'h020, 8'hFF);
    run(9'h020, 1, 1, 1, 0, 1, 0, 1, 8'h5A, -1);
    chk("t3_wr_cnt", wr_cnt, 1);
    chk("t3_wr_a", 32'(wr_a), 32'h020);
    chk("t3_wr_d", 32'(wr_d), 32'h5A);
    chk("t3_mem", 32'(mem[9'h020]), 32'h5A);
    chk("t3_done_edge", done_idx, 71);

    run(9'h055, 0, 2, 0, 0, 1, 0, 0, 0, -1);
    chk("t4_done_edge", done_idx, 1);
    chk("t4_cen", cen_cnt, 0);
    chk("t4_sclk", s1_cnt + s2_cnt, 0);
    chk("t4_lat", lat_cnt, 0);

    run(9'h010, 2, 0, 0, 0, 0, 0, 0, 0, 53);
    run(9'h010, 2, 0, 0, 0, 0, 0, 0, 0, -1);
    chk("t5_done_edge", done_idx, 72);

    run(9'h030, 3, 0, 0, 0, 0, 1, 0, 0, -1);
    chk("t6_one_done", dn_cnt, 1);
    chk("t6_words", rd_log.size(), 3);

    for (int t = 0; t < 12; t++) begin
      n   = $urandom_range(0, 3);
      d   = $urandom_range(0, 2);
      msb = 1'($urandom);
      dec = 1'($urandom);
      cap = 1'($urandom);
      run(AW'($urandom), n, d, msb, dec, cap, t[0], 0, 0, -1);
      chk($sformatf("rnd%0d_done_edge", t), done_idx,
          xfer_cycles(n, W, d, 32'(cap)));
    end

    bad = 0;
    for (int i = 0; i < (1 << AW); i++)
      if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
